// File: rtl/code_lock_pkg.sv
// Shared types and constants for the colour-button code lock.
package code_lock_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_R = 2'b01;
  localparam sym_t SYM_G = 2'b10;
  localparam sym_t SYM_B = 2'b11;

  localparam int CODE_LEN = 4;

  // Element [0] is the first symbol entered
  typedef logic [CODE_LEN-1:0][1:0] code_t;

  // R, B, G, R in entry order
  localparam code_t DEFAULT_CODE = {SYM_R, SYM_G, SYM_B, SYM_R};

  // Down-counter width for a count of n cycles (loaded with n-1), never 0
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_edge_enc.sv
// Press detection for S/R/G/B: rising edges and colour symbol encoding.
module button_edge_enc
  import code_lock_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic s,
  input  logic r,
  input  logic g,
  input  logic b,
  output sym_t sym,
  output logic sym_valid,
  output logic sym_invalid,
  output logic s_press
);

  logic [3:0] prev_q;
  logic       r_e, g_e, b_e;

  // Previous-cycle button levels
  always_ff @(posedge Clk) begin
    if (Rst) prev_q <= '0;
    else     prev_q <= {s, r, g, b};
  end

  assign s_press = s & ~prev_q[3];
  assign r_e     = r & ~prev_q[2];
  assign g_e     = g & ~prev_q[1];
  assign b_e     = b & ~prev_q[0];

  // Encode a single colour edge; two or more colour edges form one bad symbol
  always_comb begin
    sym       = 2'b00;
    sym_valid = 1'b0;
    case ({r_e, g_e, b_e})
      3'b100:  begin sym = SYM_R; sym_valid = 1'b1; end
      3'b010:  begin sym = SYM_G; sym_valid = 1'b1; end
      3'b001:  begin sym = SYM_B; sym_valid = 1'b1; end
      default: begin sym = 2'b00; sym_valid = 1'b0; end
    endcase
    sym_invalid = (r_e & g_e) | (r_e & b_e) | (g_e & b_e);
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock sequencer: entry sessions, check, unlock window, reprogramming
// while open, and failure lockout.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       S,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  input  logic       P,
  output logic       U,
  output logic       Locked,
  output logic       Fail,
  output logic [1:0] FailCnt
);

  localparam int UW = cnt_w(UNLOCK_CYCLES);
  localparam int LW = cnt_w(LOCKOUT_CYCLES);

  localparam logic [UW-1:0] U_LOAD = UW'(UNLOCK_CYCLES - 1);
  localparam logic [LW-1:0] L_LOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAILS);

  sym_t sym;
  logic sym_valid, sym_invalid, s_press;

  button_edge_enc u_enc (
    .Clk         (Clk),
    .Rst         (Rst),
    .s           (S),
    .r           (R),
    .g           (G),
    .b           (B),
    .sym         (sym),
    .sym_valid   (sym_valid),
    .sym_invalid (sym_invalid),
    .s_press     (s_press)
  );

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            mm_q, mm_d;
  logic [1:0]      pidx_q, pidx_d;
  code_t           shadow_q, shadow_d;
  code_t           code_q, code_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic [UW-1:0]   ucnt_q, ucnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [1:0]      fcnt_inc;

  assign fcnt_inc = fcnt_q + 2'd1;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mm_q     <= 1'b0;
      pidx_q   <= '0;
      shadow_q <= '0;
      code_q   <= DEFAULT_CODE;
      fcnt_q   <= '0;
      ucnt_q   <= '0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mm_q     <= mm_d;
      pidx_q   <= pidx_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      fcnt_q   <= fcnt_d;
      ucnt_q   <= ucnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mm_d     = mm_q;
    pidx_d   = pidx_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    fcnt_d   = fcnt_q;
    ucnt_d   = ucnt_q;
    lcnt_d   = lcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (s_press) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          mm_d    = 1'b0;
        end
      end

      ST_ENTRY: begin
        // S wins over a colour in the same cycle; the colour is dropped
        if (s_press) begin
          idx_d = '0;
          mm_d  = 1'b0;
        end else if (sym_valid || sym_invalid) begin
          if (sym_invalid || (sym != code_q[idx_q])) mm_d = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!mm_q) begin
          state_d = ST_OPEN;
          fcnt_d  = '0;
          ucnt_d  = U_LOAD;
        end else begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc == FAIL_MAX) begin
            state_d = ST_LOCKOUT;
            lcnt_d  = L_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_OPEN: begin
        // Program request beats expiry of the unlock window
        if (P) begin
          state_d = ST_PROG;
          pidx_d  = '0;
        end else if (ucnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ucnt_d = ucnt_q - 1'b1;
        end
      end

      ST_PROG: begin
        if (s_press) begin
          state_d = ST_IDLE;
        end else if (sym_valid) begin
          shadow_d[pidx_q] = sym;
          pidx_d = pidx_q + 2'd1;
          if (pidx_q == 2'd3) begin
            code_d  = shadow_d;
            state_d = ST_IDLE;
          end
        end
      end

      ST_LOCKOUT: begin
        if (lcnt_q == '0) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign U       = (state_q == ST_OPEN);
  assign Locked  = (state_q == ST_LOCKOUT);
  assign Fail    = (state_q == ST_CHECK) && mm_q;
  assign FailCnt = fcnt_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl. obs = {U, Locked, Fail, FailCnt}.
module tb_code_lock_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       S = 1'b0, R = 1'b0, G = 1'b0, B = 1'b0, P = 1'b0;
  logic       U, Locked, Fail;
  logic [1:0] FailCnt;
  logic [4:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] BS = 4'b1000;
  localparam logic [3:0] BR = 4'b0100;
  localparam logic [3:0] BG = 4'b0010;
  localparam logic [3:0] BB = 4'b0001;

  code_lock_ctrl #(.UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16), .MAX_FAILS(3)) dut (
    .Clk(Clk), .Rst(Rst), .S(S), .R(R), .G(G), .B(B), .P(P),
    .U(U), .Locked(Locked), .Fail(Fail), .FailCnt(FailCnt)
  );

  assign obs = {U, Locked, Fail, FailCnt};

  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic hold(input logic [3:0] m, input int n);
    {S, R, G, B} = m;
    repeat (n) @(negedge Clk);
    {S, R, G, B} = 4'b0;
  endtask

  task automatic press(input logic [3:0] m);
    hold(m, 1);
  endtask

  // S then four symbols two cycles apart; returns in the CHECK cycle
  task automatic enter(input logic [3:0] a, b, c, d);
    press(BS); idle(1);
    press(a);  idle(1);
    press(b);  idle(1);
    press(c);  idle(1);
    press(d);
  endtask

  // Step from the CHECK cycle of a correct code to OPEN cycle 3
  task automatic to_open3();
    idle(3);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    idle(2);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL reset_state got=%b exp=%b", obs, 5'b00000); end
    Rst = 1'b0;
    idle(1);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL post_reset got=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_unlock();
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL unlock_check got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL unlock_first got=%b exp=%b", obs, 5'b10000); end
    for (int i = 2; i <= 8; i++) begin
      idle(1);
      n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL unlock_cycle%0d got=%b exp=%b", i, obs, 5'b10000); end
    end
    idle(1);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL unlock_expire got=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_fail_lockout();
    enter(BR, BB, BB, BR);
    n_cmp++; if (obs !== 5'b00100) begin n_err++; $display("FAIL fail1_pulse got=%b exp=%b", obs, 5'b00100); end
    idle(1);
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL fail1_after got=%b exp=%b", obs, 5'b00001); end
    enter(BR, BB, BB, BR);
    n_cmp++; if (obs !== 5'b00101) begin n_err++; $display("FAIL fail2_pulse got=%b exp=%b", obs, 5'b00101); end
    idle(1);
    n_cmp++; if (obs !== 5'b00010) begin n_err++; $display("FAIL fail2_after got=%b exp=%b", obs, 5'b00010); end
    enter(BR, BB, BB, BR);
    n_cmp++; if (obs !== 5'b00110) begin n_err++; $display("FAIL fail3_pulse got=%b exp=%b", obs, 5'b00110); end
    idle(1);
    // Buttons toggled throughout lockout must have no effect
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (obs !== 5'b01011) begin n_err++; $display("FAIL lockout_cycle%0d got=%b exp=%b", i, obs, 5'b01011); end
      press(i[0] ? (BR | BG) : BS);
    end
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL lockout_exit got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL post_lockout_check got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL post_lockout_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
  endtask

  task automatic test_restart_multi();
    // S,R,B then S+R (restart only), R held 3 cycles (one symbol), B,G,R
    press(BS); idle(1);
    press(BR); idle(1);
    press(BB); idle(1);
    press(BS | BR); idle(1);
    hold(BR, 3); idle(1);
    press(BB); idle(1);
    press(BG); idle(1);
    press(BR);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL restart_check got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL restart_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL restart_expire got=%b exp=%b", obs, 5'b00000); end
    // R and G edges together count as one always-wrong symbol
    enter(BR, BR | BG, BG, BR);
    n_cmp++; if (obs !== 5'b00100) begin n_err++; $display("FAIL multi_pulse got=%b exp=%b", obs, 5'b00100); end
    idle(1);
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL multi_after got=%b exp=%b", obs, 5'b00001); end
  endtask

  task automatic test_prog_abort();
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL abort_check got=%b exp=%b", obs, 5'b00001); end
    to_open3();
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL abort_open3 got=%b exp=%b", obs, 5'b10000); end
    P = 1'b1; idle(1); P = 1'b0;
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL abort_prog got=%b exp=%b", obs, 5'b00000); end
    press(BG); idle(1);
    press(BG); idle(1);
    press(BS); idle(1);
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL abort_old_check got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL abort_old_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
  endtask

  task automatic test_prog();
    enter(BR, BB, BG, BR);
    to_open3();
    P = 1'b1; idle(1); P = 1'b0;
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL prog_u_drop got=%b exp=%b", obs, 5'b00000); end
    // G, (R+B ignored), G, B, R -> new code G,G,B,R
    press(BG); idle(1);
    press(BR | BB); idle(1);
    press(BG); idle(1);
    press(BB); idle(1);
    press(BR);
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00100) begin n_err++; $display("FAIL prog_old_fails got=%b exp=%b", obs, 5'b00100); end
    idle(1);
    enter(BG, BG, BB, BR);
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL prog_new_check got=%b exp=%b", obs, 5'b00001); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL prog_new_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
  endtask

  task automatic test_reset_mid();
    // Mid-ENTRY reset while the programmed code is G,G,B,R
    press(BS); idle(1);
    press(BG);
    Rst = 1'b1; idle(1); Rst = 1'b0;
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL rst_entry got=%b exp=%b", obs, 5'b00000); end
    enter(BR, BB, BG, BR);
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL rst_entry_default got=%b exp=%b", obs, 5'b00000); end
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL rst_entry_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
    // Mid-LOCKOUT reset
    repeat (3) begin enter(BB, BB, BB, BB); idle(1); end
    idle(3);
    n_cmp++; if (obs !== 5'b01011) begin n_err++; $display("FAIL rst_lock_pre got=%b exp=%b", obs, 5'b01011); end
    Rst = 1'b1; idle(1); Rst = 1'b0;
    n_cmp++; if (obs !== 5'b00000) begin n_err++; $display("FAIL rst_lockout got=%b exp=%b", obs, 5'b00000); end
    enter(BR, BB, BG, BR);
    idle(1);
    n_cmp++; if (obs !== 5'b10000) begin n_err++; $display("FAIL rst_lock_open got=%b exp=%b", obs, 5'b10000); end
    idle(8);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_restart_multi();
    test_prog_abort();
    test_prog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
